// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction store and its loader: FSM encodings, word geometry, default store size.
// No logic of its own, so no latency.
// No flow control of its own.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        FINISH    = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD    = 4;
    localparam int DEFAULT_MEM_BYTES = 400;

    // Big-endian byte k of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        b = 8'h00;
        case (k)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_byte_ser.sv
// Holds one instruction word and steps through its four bytes, most significant byte first.
// Byte data and offset are valid in the cycle after load, then advance by one per cycle.
// No backpressure: the owner advances only while it is writing.
module imem_byte_ser
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_advance,
    output logic [7:0]  o_byte,
    output logic [1:0]  o_offset,
    output logic        o_last
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
        end else if (i_advance) begin
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_byte   = word_byte(r_word, r_idx);
    assign o_offset = r_idx;
    assign o_last   = (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a run of 32-bit words into the byte-wide instruction store, big-endian; optional checksum under IMEM_LOADER_CHECKSUM_EN.
// First byte write one cycle after a word is accepted; one word per 5 cycles.
// in_ready is high only while waiting for a word, so the source is stalled for the 4 write cycles.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adrs,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_adrs;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_err;

    logic              w_start_acc;
    logic              w_accept;
    logic              w_in_range;
    logic [ADDR_W:0]   w_word_end;
    logic              w_in_ready;
    logic              w_mem_we;
    logic              w_busy;
    logic              w_done;
    logic [7:0]        w_byte;
    logic [1:0]        w_offset;
    logic              w_last;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_accept    = (r_state == WAIT_WORD) && in_valid;

    // One extra bit so a base near the top of the address space fails the check instead of wrapping into range.
    assign w_word_end  = {1'b0, r_adrs} + (ADDR_W+1)'(BYTES_PER_WORD - 1);
    assign w_in_range  = (w_word_end <= LAST_BYTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_mem_we   = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (word_cnt == '0) ? FINISH : WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (in_valid) begin
                    w_next = w_in_range ? WRITE : FINISH;
                end
            end
            WRITE: begin
                w_mem_we = 1'b1;
                w_busy   = 1'b1;
                if (w_last) begin
                    w_next = (r_remaining == CNT_W'(1)) ? FINISH : WAIT_WORD;
                end
            end
            FINISH: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adrs      <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_adrs      <= base_adrs;
                r_remaining <= word_cnt;
                r_err       <= 1'b0;
            end
            if (w_accept && !w_in_range) begin
                r_err <= 1'b1;
            end
            if (w_mem_we && w_last) begin
                r_adrs      <= r_adrs + ADDR_W'(BYTES_PER_WORD);
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    imem_byte_ser u_byte_ser (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept && w_in_range),
        .i_word    (in_data),
        .i_advance (w_mem_we),
        .o_byte    (w_byte),
        .o_offset  (w_offset),
        .o_last    (w_last)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_accept && w_in_range) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'h0;
`endif

    // Address and data are forced to zero outside writes so the port is quiet when idle.
    assign mem_adrs  = w_mem_we ? (r_adrs + ADDR_W'(w_offset)) : '0;
    assign mem_wdata = w_mem_we ? w_byte : 8'h00;
    assign mem_we    = w_mem_we;
    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign done      = w_done;
    assign err       = r_err;

endmodule
